i2s_in_arb: RTL and testbench

Round-robin arbiter that merges the per-channel push-only AXI-Stream outputs of the 16-lane I2S receiver into a single back-pressured AXI-Stream toward the packetiser. Each lane has a one-word holding buffer. The arbiter grants one pending lane per output slot and tags each word with its lane index and destination FPGA index. Lane words that arrive while the lane's buffer is still occupied are dropped and flagged, because the receiver cannot be stalled.

---
 rtl/i2s_in_arb.sv | 168 ++++++++++++++++
 tb/tb_i2s_in_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_in_arb.sv
// i2s_in_arb: round-robin merge of 16 push-only I2S lane streams into one
// back-pressured AXI-Stream, with one holding word per lane and drop flags.
// Optional feature macro: I2S_ARB_DROP_CNT_EN (per-lane 8-bit drop counters).
module i2s_in_arb #(
    parameter int unsigned CH_NUM     = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic                         mclki,
    input  logic                         arst_n,
    input  logic [CH_NUM-1:0]            s_axis_tvalid,
    input  logic [CH_NUM*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CH_NUM-1:0]            s_axis_tlast,
    input  logic [CH_NUM-1:0]            i_enable,
    input  logic [4*CH_NUM-1:0]          i_dst_fpga_index,
    input  logic                         i_ovf_clr,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic [IDX_WIDTH-1:0]         m_axis_tid,
    output logic [3:0]                   m_axis_tdest,
    output logic [CH_NUM-1:0]            o_overflow,
    output logic [8*CH_NUM-1:0]          o_drop_cnt
);

    localparam int unsigned DST_W = 4;
    localparam int unsigned CNT_W = 8;

    logic [CH_NUM-1:0]     hold_vld;
    logic [CH_NUM-1:0]     hold_last;
    logic [DATA_WIDTH-1:0] hold_data [CH_NUM];
    logic [IDX_WIDTH-1:0]  rr_ptr;

    logic [DATA_WIDTH-1:0] lane_data_c [CH_NUM];
    logic [DST_W-1:0]      lane_dst_c  [CH_NUM];

    logic                  slot_free_c;
    logic                  gnt_vld_c;
    logic [IDX_WIDTH-1:0]  gnt_idx_c;
    logic [CH_NUM-1:0]     gnt_hot_c;
    logic [CH_NUM-1:0]     push_c;
    logic [CH_NUM-1:0]     cap_c;
    logic [CH_NUM-1:0]     drop_c;
    logic [IDX_WIDTH-1:0]  cand_c;
    int unsigned           cand_sum_c;

    // Unpack the flat per-lane data and destination buses
    for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
        assign lane_data_c[k] = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        assign lane_dst_c[k]  = i_dst_fpga_index[k*DST_W +: DST_W];
    end

    assign slot_free_c = !m_axis_tvalid || m_axis_tready;
    assign push_c      = s_axis_tvalid & i_enable;
    // A granted lane can take a new word in the same cycle its old one leaves
    assign cap_c       = push_c & (~hold_vld | gnt_hot_c);
    assign drop_c      = push_c & hold_vld & ~gnt_hot_c;

    // Circular search for the first pending lane starting at rr_ptr
    always_comb begin
        gnt_vld_c  = 1'b0;
        gnt_idx_c  = '0;
        gnt_hot_c  = '0;
        cand_c     = '0;
        cand_sum_c = 0;
        if (slot_free_c) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                cand_sum_c = 32'(rr_ptr) + i;
                if (cand_sum_c >= CH_NUM) begin
                    cand_sum_c = cand_sum_c - CH_NUM;
                end
                cand_c = IDX_WIDTH'(cand_sum_c);
                if (!gnt_vld_c && hold_vld[cand_c]) begin
                    gnt_vld_c = 1'b1;
                    gnt_idx_c = cand_c;
                end
            end
        end
        if (gnt_vld_c) begin
            gnt_hot_c[gnt_idx_c] = 1'b1;
        end
    end

    // Per-lane holding buffers: capture, release on grant, flush on disable
    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) begin
            hold_vld  <= '0;
            hold_last <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                hold_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (cap_c[k]) begin
                    hold_vld[k]  <= 1'b1;
                    hold_data[k] <= lane_data_c[k];
                    hold_last[k] <= s_axis_tlast[k];
                end else if (gnt_hot_c[k] || !i_enable[k]) begin
                    hold_vld[k]  <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            rr_ptr        <= '0;
        end else if (gnt_vld_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hold_data[gnt_idx_c];
            m_axis_tlast  <= hold_last[gnt_idx_c];
            m_axis_tid    <= gnt_idx_c;
            m_axis_tdest  <= lane_dst_c[gnt_idx_c];
            rr_ptr        <= (gnt_idx_c == IDX_WIDTH'(CH_NUM-1)) ? '0
                                                                 : gnt_idx_c + IDX_WIDTH'(1);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Sticky drop flags; a new drop beats a simultaneous clear
    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) begin
            o_overflow <= '0;
        end else begin
            o_overflow <= drop_c | (i_ovf_clr ? '0 : o_overflow);
        end
    end

`ifdef I2S_ARB_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt [CH_NUM];

    // Saturating per-lane drop counters; increment on clear yields 1
    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < CH_NUM; k++) begin
                drop_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (drop_c[k]) begin
                    if (i_ovf_clr) begin
                        drop_cnt[k] <= CNT_W'(1);
                    end else if (drop_cnt[k] != '1) begin
                        drop_cnt[k] <= drop_cnt[k] + CNT_W'(1);
                    end
                end else if (i_ovf_clr) begin
                    drop_cnt[k] <= '0;
                end
            end
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_cnt
        assign o_drop_cnt[k*CNT_W +: CNT_W] = drop_cnt[k];
    end
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_in_arb.sv
// Directed table-driven bench for i2s_in_arb plus hand-written reset sequence.
module tb_i2s_in_arb;

    logic          mclki;
    logic          arst_n;
    logic [15:0]   s_axis_tvalid;
    logic [511:0]  s_axis_tdata;
    logic [15:0]   s_axis_tlast;
    logic [15:0]   i_enable;
    logic [63:0]   i_dst_fpga_index;
    logic          i_ovf_clr;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tlast;
    logic [3:0]    m_axis_tid;
    logic [3:0]    m_axis_tdest;
    logic [15:0]   o_overflow;
    logic [127:0]  o_drop_cnt;

    i2s_in_arb dut (
        .mclki            (mclki),
        .arst_n           (arst_n),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .i_enable         (i_enable),
        .i_dst_fpga_index (i_dst_fpga_index),
        .i_ovf_clr        (i_ovf_clr),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tid       (m_axis_tid),
        .m_axis_tdest     (m_axis_tdest),
        .o_overflow       (o_overflow),
        .o_drop_cnt       (o_drop_cnt)
    );

    initial mclki = 1'b0;
    always #5 mclki = ~mclki;

    typedef struct {
        logic [15:0] en;
        logic [15:0] vld;
        logic [15:0] last;
        logic [31:0] data;   // lane k drives data + k
        logic        tr;
        logic        clr;
        logic        e_tv;
        logic [31:0] e_data;
        logic [3:0]  e_tid;
        logic        e_last;
        logic [3:0]  e_dest;
        logic [15:0] e_ovf;
        logic [7:0]  e_dc2;  // lane 2 drop count when counters are built in
    } vec_t;

    localparam int NV = 34;
    vec_t vt [NV];

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic [15:0] en, input logic [15:0] vld,
                                input logic [15:0] last, input logic [31:0] data,
                                input logic tr, input logic clr, input logic e_tv,
                                input logic [31:0] e_data, input logic [3:0] e_tid,
                                input logic e_last, input logic [3:0] e_dest,
                                input logic [15:0] e_ovf, input logic [7:0] e_dc2);
        vec_t v;
        v.en = en; v.vld = vld; v.last = last; v.data = data; v.tr = tr; v.clr = clr;
        v.e_tv = e_tv; v.e_data = e_data; v.e_tid = e_tid; v.e_last = e_last;
        v.e_dest = e_dest; v.e_ovf = e_ovf; v.e_dc2 = e_dc2;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] en, input logic [15:0] vld, input logic [15:0] last,
                         input logic [31:0] data, input logic tr, input logic clr);
        i_enable      = en;
        s_axis_tvalid = vld;
        s_axis_tlast  = last;
        m_axis_tready = tr;
        i_ovf_clr     = clr;
        for (int k = 0; k < 16; k++) begin
            s_axis_tdata[k*32 +: 32] = data + 32'(k);
        end
    endtask

    task automatic step();
        @(posedge mclki);
        #1;
        n_vec++;
    endtask

    function automatic logic [127:0] exp_dcnt(input logic [7:0] dc2);
`ifdef I2S_ARB_DROP_CNT_EN
        return 128'(dc2) << 16;
`else
        return (dc2 == 8'd0) ? 128'd0 : 128'd0;
`endif
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tvalid"}, 128'(m_axis_tvalid), 128'd0);
        check({tag, "_tdata"},  128'(m_axis_tdata),  128'd0);
        check({tag, "_tlast"},  128'(m_axis_tlast),  128'd0);
        check({tag, "_tid"},    128'(m_axis_tid),    128'd0);
        check({tag, "_tdest"},  128'(m_axis_tdest),  128'd0);
        check({tag, "_ovf"},    128'(o_overflow),    128'd0);
        check({tag, "_dcnt"},   o_drop_cnt,          128'd0);
    endtask

    localparam logic [15:0] EN = 16'hFFFF;
    localparam logic [15:0] ND = 16'hFDFF;

    initial begin
        // Lane k is routed to destination 15-k
        for (int k = 0; k < 16; k++) begin
            i_dst_fpga_index[k*4 +: 4] = 4'(15 - k);
        end

        // Round-robin from reset, wrap, single lane, back-pressure, overflow,
        // set/clear priority, grant/capture collision, disable flush
        vt[0]  = mk(EN, 16'h8021, 16'h8000, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[1]  = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 4'd0, 1'b0, 4'd15, 16'h0, 8'd0);
        vt[2]  = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_1005, 4'd5, 1'b0, 4'd10, 16'h0, 8'd0);
        vt[3]  = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_100F, 4'd15, 1'b1, 4'd0, 16'h0, 8'd0);
        vt[4]  = mk(EN, 16'h8001, 16'h0001, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[5]  = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 4'd0, 1'b1, 4'd15, 16'h0, 8'd0);
        vt[6]  = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_200F, 4'd15, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[7]  = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[8]  = mk(EN, 16'h0008, 16'h0008, 32'hA5A4_FFFE, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[9]  = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 4'd3, 1'b1, 4'd12, 16'h0, 8'd0);
        vt[10] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[11] = mk(EN, 16'h0004, 16'h0, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[12] = mk(EN, 16'h0004, 16'h0, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 4'd2, 1'b0, 4'd13, 16'h0, 8'd0);
        vt[13] = mk(EN, 16'h0004, 16'h0, 32'h0000_0031, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 4'd2, 1'b0, 4'd13, 16'h0004, 8'd1);
        vt[14] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0022, 4'd2, 1'b0, 4'd13, 16'h0004, 8'd1);
        vt[15] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[16] = mk(EN, 16'h0004, 16'h0, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[17] = mk(EN, 16'h0004, 16'h0, 32'h0000_0053, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 4'd2, 1'b0, 4'd13, 16'h0, 8'd0);
        vt[18] = mk(EN, 16'h0004, 16'h0, 32'h0000_0064, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 4'd2, 1'b0, 4'd13, 16'h0004, 8'd1);
        vt[19] = mk(EN, 16'h0004, 16'h0, 32'h0000_0075, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 4'd2, 1'b0, 4'd13, 16'h0004, 8'd1);
        vt[20] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 4'd2, 1'b0, 4'd13, 16'h0, 8'd0);
        vt[21] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0055, 4'd2, 1'b0, 4'd13, 16'h0, 8'd0);
        vt[22] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[23] = mk(EN, 16'h0080, 16'h0, 32'h0000_0700, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[24] = mk(EN, 16'h0080, 16'h0, 32'h0000_0800, 1'b0, 1'b0, 1'b1, 32'h0000_0707, 4'd7, 1'b0, 4'd8, 16'h0, 8'd0);
        vt[25] = mk(EN, 16'h0080, 16'h0, 32'h0000_0900, 1'b1, 1'b0, 1'b1, 32'h0000_0807, 4'd7, 1'b0, 4'd8, 16'h0, 8'd0);
        vt[26] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0907, 4'd7, 1'b0, 4'd8, 16'h0, 8'd0);
        vt[27] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[28] = mk(EN, 16'h0002, 16'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[29] = mk(EN, 16'h0200, 16'h0, 32'h0000_0900, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 4'd1, 1'b0, 4'd14, 16'h0, 8'd0);
        vt[30] = mk(ND, 16'h0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 4'd1, 1'b0, 4'd14, 16'h0, 8'd0);
        vt[31] = mk(ND, 16'h0200, 16'h0, 32'h0000_0A00, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 4'd1, 1'b0, 4'd14, 16'h0, 8'd0);
        vt[32] = mk(ND, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);
        vt[33] = mk(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 16'h0, 8'd0);

        // Reset state
        arst_n = 1'b0;
        drive(EN, 16'h0, 16'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check_zero_outputs("reset");
        @(negedge mclki);
        arst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].en, vt[i].vld, vt[i].last, vt[i].data, vt[i].tr, vt[i].clr);
            step();
            check($sformatf("v%0d_tvalid", i), 128'(m_axis_tvalid), 128'(vt[i].e_tv));
            check($sformatf("v%0d_ovf", i), 128'(o_overflow), 128'(vt[i].e_ovf));
            check($sformatf("v%0d_dcnt", i), o_drop_cnt, exp_dcnt(vt[i].e_dc2));
            if (vt[i].e_tv) begin
                check($sformatf("v%0d_tdata", i), 128'(m_axis_tdata), 128'(vt[i].e_data));
                check($sformatf("v%0d_tid", i), 128'(m_axis_tid), 128'(vt[i].e_tid));
                check($sformatf("v%0d_tlast", i), 128'(m_axis_tlast), 128'(vt[i].e_last));
                check($sformatf("v%0d_tdest", i), 128'(m_axis_tdest), 128'(vt[i].e_dest));
            end
        end

        // Reset asserted mid-transfer with lane 4 streaming and an overflow pending
        drive(EN, 16'h0010, 16'h0, 32'h0000_4440, 1'b0, 1'b0);
        step();
        drive(EN, 16'h0010, 16'h0, 32'h0000_4441, 1'b0, 1'b0);
        step();
        check("pre_rst_tdata", 128'(m_axis_tdata), 128'h4444);
        drive(EN, 16'h0010, 16'h0, 32'h0000_4442, 1'b0, 1'b0);
        step();
        check("pre_rst_ovf", 128'(o_overflow), 128'h0010);
        #2;
        arst_n = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        @(negedge mclki);
        arst_n = 1'b1;
        drive(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_rst%0d_tvalid", c), 128'(m_axis_tvalid), 128'd0);
        end

        // rr_ptr restarts at 0: lanes 1 and 6 come out in order 1, 6
        drive(EN, 16'h0042, 16'h0, 32'h0000_0600, 1'b1, 1'b0);
        step();
        check("rr0_cap_tvalid", 128'(m_axis_tvalid), 128'd0);
        drive(EN, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("rr0_a_tvalid", 128'(m_axis_tvalid), 128'd1);
        check("rr0_a_tid", 128'(m_axis_tid), 128'd1);
        check("rr0_a_tdata", 128'(m_axis_tdata), 128'h0601);
        step();
        check("rr0_b_tid", 128'(m_axis_tid), 128'd6);
        check("rr0_b_tdata", 128'(m_axis_tdata), 128'h0606);
        check("rr0_b_tdest", 128'(m_axis_tdest), 128'd9);
        step();
        check("rr0_idle_tvalid", 128'(m_axis_tvalid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
